// File: rtl/canvas_sequencer_pkg.sv
// rtl/canvas_sequencer_pkg.sv - shared state encoding, key indices and grid defaults
package canvas_sequencer_pkg;

  localparam int GRID_W_DEFAULT = 28;
  localparam int GRID_H_DEFAULT = 28;

  localparam logic [1:0] KEY_DOWN  = 2'd0;
  localparam logic [1:0] KEY_UP    = 2'd1;
  localparam logic [1:0] KEY_LEFT  = 2'd2;
  localparam logic [1:0] KEY_RIGHT = 2'd3;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    DRAW        = 3'd1,
    CLEAR       = 3'd2,
    INFER_START = 3'd3,
    INFER_WAIT  = 3'd4
  } state_t;

endpackage

// File: rtl/canvas_sequencer_if.sv
// rtl/canvas_sequencer_if.sv - board, image memory and inference engine signals of the sequencer
interface canvas_sequencer_if #(
  parameter int ADDR_W = 10
);
  logic [3:0]        key_n;
  logic              draw_en;
  logic              pen_on;
  logic              start;
  logic              clear;
  logic              nn_rd_req;
  logic [ADDR_W-1:0] nn_rd_addr;
  logic              nn_done;
  logic [3:0]        nn_result;
  logic              img_we;
  logic [ADDR_W-1:0] img_addr;
  logic              img_wdata;
  logic              nn_rd_gnt;
  logic              nn_start;
  logic [4:0]        cursor_x;
  logic [4:0]        cursor_y;
  logic [3:0]        digit;
  logic              result_valid;
  logic              busy;
  logic [2:0]        state;

  // Sequencer side
  modport master (
    input  key_n, draw_en, pen_on, start, clear,
    input  nn_rd_req, nn_rd_addr, nn_done, nn_result,
    output img_we, img_addr, img_wdata, nn_rd_gnt, nn_start,
    output cursor_x, cursor_y, digit, result_valid, busy, state
  );

  // Board / memory / engine side
  modport slave (
    output key_n, draw_en, pen_on, start, clear,
    output nn_rd_req, nn_rd_addr, nn_done, nn_result,
    input  img_we, img_addr, img_wdata, nn_rd_gnt, nn_start,
    input  cursor_x, cursor_y, digit, result_valid, busy, state
  );
endinterface

// File: rtl/canvas_sequencer_key_debouncer.sv
// rtl/canvas_sequencer_key_debouncer.sv - single-key debounce producing one move pulse per press
module canvas_sequencer_key_debouncer
  import canvas_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_n_sync,
  output logic       move,
  output logic [1:0] dir
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [3:0]       pressed;
  logic [3:0]       last;
  logic [CNT_W-1:0] cnt;
  logic             locked;
  logic             one_hot;
  logic [1:0]       key_idx;

  assign pressed = ~key_n_sync;
  assign one_hot = (pressed != 4'd0) && ((pressed & (pressed - 4'd1)) == 4'd0);

  // Direction of the single pressed key
  always_comb begin
    case (pressed)
      4'b0010: key_idx = KEY_UP;
      4'b0100: key_idx = KEY_LEFT;
      4'b1000: key_idx = KEY_RIGHT;
      default: key_idx = KEY_DOWN;
    endcase
  end

  // Count stable single-key cycles; fire once, then stay locked until all keys release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      last   <= 4'd0;
      locked <= 1'b0;
      move   <= 1'b0;
      dir    <= KEY_DOWN;
    end else begin
      move <= 1'b0;
      last <= pressed;
      if (pressed == 4'd0) begin
        cnt    <= '0;
        locked <= 1'b0;
      end else if (locked || !one_hot || (pressed != last)) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        cnt    <= '0;
        locked <= 1'b1;
        move   <= 1'b1;
        dir    <= key_idx;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/canvas_sequencer.sv
// rtl/canvas_sequencer.sv - canvas drawing, clear sweep and inference hand-off controller
module canvas_sequencer
  import canvas_sequencer_pkg::*;
#(
  parameter int GRID_W          = GRID_W_DEFAULT,
  parameter int GRID_H          = GRID_H_DEFAULT,
  parameter int ADDR_W          = 10,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  canvas_sequencer_if.master bus
);

  localparam logic [4:0]        X_MAX     = 5'(GRID_W - 1);
  localparam logic [4:0]        Y_MAX     = 5'(GRID_H - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(GRID_W * GRID_H - 1);

  state_t            state, next_state;
  logic [3:0]        key_meta, key_sync;
  logic [2:0]        start_sr, clear_sr;
  logic              start_edge, clear_edge;
  logic              mv;
  logic [1:0]        mv_dir;
  logic [4:0]        cursor_x, cursor_y, nx, ny;
  logic              move_ok;
  logic              pend_write;
  logic [ADDR_W-1:0] clr_addr;
  logic [3:0]        digit;
  logic              result_valid;
  logic              img_we, img_wdata, nn_rd_gnt, nn_start;
  logic [ADDR_W-1:0] img_addr;

  // Row-major pixel address, y*GRID_W built from shifted copies of y
  function automatic logic [ADDR_W-1:0] pixel_addr(input logic [4:0] x, input logic [4:0] y);
    logic [ADDR_W-1:0] acc;
    acc = ADDR_W'(x);
    for (int b = 0; b < ADDR_W; b++) begin
      if (((GRID_W >> b) & 1) != 0) acc = acc + (ADDR_W'(y) << b);
    end
    return acc;
  endfunction

  // Two-flop synchronizers; the third start/clear stage is kept for edge detection
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      key_meta <= 4'hF;
      key_sync <= 4'hF;
      start_sr <= 3'd0;
      clear_sr <= 3'd0;
    end else begin
      key_meta <= bus.key_n;
      key_sync <= key_meta;
      start_sr <= {start_sr[1:0], bus.start};
      clear_sr <= {clear_sr[1:0], bus.clear};
    end
  end

  assign start_edge = start_sr[1] & ~start_sr[2];
  assign clear_edge = clear_sr[1] & ~clear_sr[2];

  canvas_sequencer_key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk       (CLOCK_50),
    .rst       (reset),
    .key_n_sync(key_sync),
    .move      (mv),
    .dir       (mv_dir)
  );

  // Saturating target cursor for the pending move direction
  always_comb begin
    nx = cursor_x;
    ny = cursor_y;
    case (mv_dir)
      KEY_DOWN:  if (cursor_y != Y_MAX) ny = cursor_y + 5'd1;
      KEY_UP:    if (cursor_y != 5'd0)  ny = cursor_y - 5'd1;
      KEY_LEFT:  if (cursor_x != 5'd0)  nx = cursor_x - 5'd1;
      default:   if (cursor_x != X_MAX) nx = cursor_x + 5'd1;
    endcase
  end

  assign move_ok = (state == DRAW) && mv && ((nx != cursor_x) || (ny != cursor_y));

  // State register
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state selection; clear outranks start in IDLE
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (clear_edge)       next_state = CLEAR;
        else if (start_edge)  next_state = INFER_START;
        else if (bus.draw_en) next_state = DRAW;
      end
      DRAW:        if (!bus.draw_en) next_state = IDLE;
      CLEAR:       if (clr_addr == LAST_ADDR) next_state = IDLE;
      INFER_START: next_state = INFER_WAIT;
      INFER_WAIT:  if (bus.nn_done) next_state = IDLE;
      default:     next_state = IDLE;
    endcase
  end

  // Memory port mux and engine handshake outputs
  always_comb begin
    img_we    = pend_write;
    img_wdata = pend_write;
    img_addr  = pend_write ? pixel_addr(cursor_x, cursor_y) : '0;
    nn_rd_gnt = 1'b0;
    nn_start  = 1'b0;
    case (state)
      CLEAR: begin
        img_we    = 1'b1;
        img_wdata = 1'b0;
        img_addr  = clr_addr;
      end
      INFER_START: begin
        img_we   = 1'b0;
        nn_start = 1'b1;
      end
      INFER_WAIT: begin
        img_we    = 1'b0;
        img_addr  = bus.nn_rd_addr;
        nn_rd_gnt = bus.nn_rd_req;
      end
      default: ;
    endcase
  end

  // Cursor, paint request, clear sweep counter and prediction latch
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      cursor_x     <= 5'(GRID_W / 2);
      cursor_y     <= 5'(GRID_H / 2);
      pend_write   <= 1'b0;
      clr_addr     <= '0;
      digit        <= 4'd0;
      result_valid <= 1'b0;
    end else begin
      pend_write <= bus.pen_on &&
                    (((state == IDLE) && (next_state == DRAW)) || move_ok);
      if (move_ok) begin
        cursor_x <= nx;
        cursor_y <= ny;
      end
      clr_addr <= ((state == CLEAR) && (next_state == CLEAR)) ? clr_addr + 1'b1 : '0;
      if ((state == IDLE) && (next_state != IDLE)) result_valid <= 1'b0;
      if ((state == INFER_WAIT) && bus.nn_done) begin
        digit        <= bus.nn_result;
        result_valid <= 1'b1;
      end
    end
  end

  assign bus.img_we       = img_we;
  assign bus.img_addr     = img_addr;
  assign bus.img_wdata    = img_wdata;
  assign bus.nn_rd_gnt    = nn_rd_gnt;
  assign bus.nn_start     = nn_start;
  assign bus.cursor_x     = cursor_x;
  assign bus.cursor_y     = cursor_y;
  assign bus.digit        = digit;
  assign bus.result_valid = result_valid;
  assign bus.busy         = (state == CLEAR) || (state == INFER_START) || (state == INFER_WAIT);
  assign bus.state        = state;

endmodule

// File: tb/tb_canvas_sequencer.sv
// tb/tb_canvas_sequencer.sv - self-checking bench for canvas_sequencer
module tb_canvas_sequencer;

  localparam int GW = 28;
  localparam int GH = 28;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  canvas_sequencer_if #(.ADDR_W(10)) bus();

  canvas_sequencer #(
    .GRID_W(GW), .GRID_H(GH), .ADDR_W(10), .DEBOUNCE_CYCLES(16)
  ) dut (
    .CLOCK_50(clk),
    .reset   (rst),
    .bus     (bus)
  );

  typedef struct {
    logic [3:0] keys;
    int         hold;
    int         ex;
    int         ey;
    int         ewr;
  } vec_t;

  vec_t tbl[21];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   ns_cnt = 0;
  int   bad_we = 0;
  int   busy_gap = 0;
  int   wr_a[$];
  int   wr_d[$];
  int   wr_c[$];

  // Record memory writes and pulses away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      cyc <= cyc + 1;
      if (bus.img_we === 1'b1) begin
        wr_a.push_back(int'(bus.img_addr));
        wr_d.push_back(int'(bus.img_wdata));
        wr_c.push_back(cyc);
        if (bus.img_wdata == 1'b0 && bus.busy != 1'b1) busy_gap <= busy_gap + 1;
        if (bus.state == 3'd3 || bus.state == 3'd4) bad_we <= bad_we + 1;
      end
      if (bus.nn_start === 1'b1) ns_cnt <= ns_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic flush();
    wr_a.delete();
    wr_d.delete();
    wr_c.delete();
  endtask

  task automatic press(input logic [3:0] keys, input int hold);
    bus.key_n = ~keys;
    step(hold);
    bus.key_n = 4'hF;
    step(10);
  endtask

  task automatic check_move(input string tag, input int ex, input int ey, input int ewr);
    chk({tag, "_x"}, bus.cursor_x, ex);
    chk({tag, "_y"}, bus.cursor_y, ey);
    if (ewr < 0) begin
      chk({tag, "_nwr"}, wr_a.size(), 0);
    end else begin
      chk({tag, "_nwr"}, wr_a.size(), 1);
      if (wr_a.size() == 1) begin
        chk({tag, "_addr"}, wr_a[0], ewr);
        chk({tag, "_data"}, wr_d[0], 1);
      end
    end
    flush();
  endtask

  initial begin
    logic [3:0] k;
    int d, hold, nx, ny, ewr, cx, cy, bad, addr;
    bit long_hold, pen;

    tbl[0] = '{4'b1000, 40, 15, 14, 407};
    tbl[1] = '{4'b1000, 40, 16, 14, 408};
    tbl[2] = '{4'b1000, 40, 17, 14, 409};
    tbl[3] = '{4'b0001, 40, 17, 15, 437};
    tbl[4] = '{4'b0001, 40, 17, 16, 465};
    tbl[5] = '{4'b0001, 40, 17, 17, 493};
    tbl[6] = '{4'b1000, 10, 17, 17, -1};
    tbl[7] = '{4'b0110, 40, 17, 17, -1};
    for (int i = 0; i < 10; i++) tbl[8 + i] = '{4'b1000, 40, 18 + i, 17, 17 * GW + 18 + i};
    tbl[18] = '{4'b1000, 40, 27, 17, -1};
    tbl[19] = '{4'b0100, 40, 26, 17, 502};
    tbl[20] = '{4'b0010, 40, 26, 16, 474};

    bus.key_n = 4'hF; bus.draw_en = 0; bus.pen_on = 0; bus.start = 0; bus.clear = 0;
    bus.nn_rd_req = 0; bus.nn_rd_addr = '0; bus.nn_done = 0; bus.nn_result = '0;
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    step(2);

    chk("rst_state", bus.state, 0);
    chk("rst_cx", bus.cursor_x, 14);
    chk("rst_cy", bus.cursor_y, 14);
    chk("rst_we", bus.img_we, 0);
    chk("rst_nn_start", bus.nn_start, 0);
    chk("rst_gnt", bus.nn_rd_gnt, 0);
    chk("rst_valid", bus.result_valid, 0);
    chk("rst_busy", bus.busy, 0);

    flush();
    bus.pen_on = 1; bus.draw_en = 1;
    step(4);
    chk("draw_state", bus.state, 1);
    check_move("entry", 14, 14, 406);

    for (int i = 0; i < 21; i++) begin
      press(tbl[i].keys, tbl[i].hold);
      check_move($sformatf("vec%0d", i), tbl[i].ex, tbl[i].ey, tbl[i].ewr);
    end

    cx = 26; cy = 16;
    for (int i = 0; i < 24; i++) begin
      d = $urandom_range(0, 3);
      k = 4'b0001 << d;
      if ($urandom_range(0, 4) == 0) k = k | (4'b0001 << ((d + $urandom_range(1, 3)) % 4));
      long_hold = ($urandom_range(0, 2) != 0);
      hold = long_hold ? $urandom_range(30, 45) : $urandom_range(3, 10);
      pen = 1'($urandom_range(0, 1));
      bus.pen_on = pen;
      nx = cx; ny = cy; ewr = -1;
      if (long_hold && $countones(k) == 1) begin
        case (d)
          0: ny = (cy < GH - 1) ? cy + 1 : cy;
          1: ny = (cy > 0) ? cy - 1 : cy;
          2: nx = (cx > 0) ? cx - 1 : cx;
          default: nx = (cx < GW - 1) ? cx + 1 : cx;
        endcase
      end
      if ((nx != cx || ny != cy) && pen) ewr = ny * GW + nx;
      press(k, hold);
      check_move($sformatf("rnd%0d", i), nx, ny, ewr);
      cx = nx; cy = ny;
    end

    bus.pen_on = 0; bus.draw_en = 0;
    step(4);
    chk("exit_draw_state", bus.state, 0);
    flush();

    bus.clear = 1; step(3); bus.clear = 0;
    for (int n = 0; n < 2000 && !(bus.state == 3'd0 && wr_a.size() > 0); n++) step(1);
    chk("clr_done_state", bus.state, 0);
    chk("clr_count", wr_a.size(), 784);
    bad = 0;
    for (int j = 0; j < wr_a.size() && j < 784; j++)
      if (wr_a[j] != j || wr_d[j] != 0 || wr_c[j] != wr_c[0] + j) bad++;
    chk("clr_seq", bad, 0);
    chk("clr_busy", busy_gap, 0);
    chk("clr_cx_hold", bus.cursor_x, cx);
    chk("clr_cy_hold", bus.cursor_y, cy);
    flush();

    bus.start = 1; step(1); bus.start = 0;
    for (int n = 0; n < 20 && bus.state != 3'd4; n++) step(1);
    chk("inf_wait_state", bus.state, 4);
    chk("inf_busy", bus.busy, 1);
    chk("nn_start_pulses", ns_cnt, 1);
    for (int i = 0; i < 6; i++) begin
      bus.nn_rd_req = 1'($urandom_range(0, 1));
      addr = $urandom_range(0, 1023);
      bus.nn_rd_addr = 10'(addr);
      #1;
      chk($sformatf("gnt%0d", i), bus.nn_rd_gnt, bus.nn_rd_req);
      chk($sformatf("rdaddr%0d", i), bus.img_addr, addr);
      chk($sformatf("rdwe%0d", i), bus.img_we, 0);
    end
    bus.nn_rd_req = 0;
    press(4'b1000, 40);
    chk("inf_key_cx", bus.cursor_x, cx);
    chk("inf_key_cy", bus.cursor_y, cy);
    chk("inf_key_nwr", wr_a.size(), 0);
    chk("inf_still_wait", bus.state, 4);
    bus.nn_result = 4'd7; bus.nn_done = 1;
    step(1);
    bus.nn_done = 0; bus.nn_result = 4'd0;
    step(1);
    chk("digit", bus.digit, 7);
    chk("result_valid", bus.result_valid, 1);
    chk("inf_done_state", bus.state, 0);
    chk("nn_start_once", ns_cnt, 1);
    chk("no_we_in_infer", bad_we, 0);
    flush();

    bus.clear = 1; step(1); bus.clear = 0;
    for (int n = 0; n < 1200 && !(bus.img_we === 1'b1 && bus.img_addr == 10'd300); n++) step(1);
    chk("clr_at_300", bus.img_addr, 300);
    rst = 1'b1;
    #1;
    chk("rst_mid_we", bus.img_we, 0);
    chk("rst_mid_state", bus.state, 0);
    chk("rst_mid_cx", bus.cursor_x, 14);
    chk("rst_mid_valid", bus.result_valid, 0);
    step(2);
    rst = 1'b0;
    step(2);
    bus.start = 1; bus.clear = 1;
    step(1);
    bus.start = 0; bus.clear = 0;
    for (int n = 0; n < 10 && bus.state == 3'd0; n++) step(1);
    chk("both_edges_state", bus.state, 2);
    for (int n = 0; n < 1000 && bus.state != 3'd0; n++) step(1);
    chk("both_edges_end", bus.state, 0);
    chk("both_edges_no_start", bus.nn_start, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/canvas_sequencer.md
Name: canvas_sequencer

Overview:
Control block between the pushbutton/switch inputs, the 28x28 1-bit image memory and the inference engine. Debounces KEY presses into cursor moves and paints pixels while drawing is enabled. Clears the canvas on request. Hands the single image-memory port to the inference engine, starts it, and latches its predicted digit on completion.

Parameters:
GRID_W, 28, canvas width in pixels
GRID_H, 28, canvas height in pixels
ADDR_W, 10, image memory address width (must satisfy GRID_W*GRID_H <= 2**ADDR_W)
DEBOUNCE_CYCLES, 500000, stable-press cycles before a key is accepted (benches use 16)

Ports:
CLOCK_50  in  1  system clock
reset  in  1  asynchronous, active-high reset
key_n  in  4  raw pushbuttons, active-low; [0] down, [1] up, [2] left, [3] right
draw_en  in  1  drawing mode (level)
pen_on  in  1  paint while moving (level)
start  in  1  inference request; rising edge acts
clear  in  1  canvas clear request; rising edge acts
nn_rd_req  in  1  inference engine read request
nn_rd_addr  in  ADDR_W  inference engine read address
nn_done  in  1  inference complete pulse
nn_result  in  4  predicted digit, valid with nn_done
img_we  out  1  image memory write enable
img_addr  out  ADDR_W  image memory address (muxed)
img_wdata  out  1  image memory write data
nn_rd_gnt  out  1  read grant to inference engine
nn_start  out  1  one-cycle start pulse
cursor_x  out  5  cursor column
cursor_y  out  5  cursor row
digit  out  4  latched prediction
result_valid  out  1  digit is valid
busy  out  1  state is CLEAR, INFER_START or INFER_WAIT
state  out  3  FSM state, for LEDR debug

Behaviour:
- Reset (asynchronous, any state): state=IDLE; cursor=(GRID_W/2, GRID_H/2)=(14,14); all other outputs 0; debounce counters cleared; any sweep or inference abandoned.
- key_n, start and clear each pass through a 2-flop synchronizer. Edge detection runs on the synchronized signals.
- Debounce: exactly one key pressed and stable for DEBOUNCE_CYCLES yields a single move. A new move requires all keys to be released first. If two or more keys are pressed, no move occurs and the counter resets. Any change in the pressed key also resets the counter.
- Moves saturate at 0 and GRID-1. A saturated move updates nothing and writes nothing.
- Pixel address = cursor_y*GRID_W + cursor_x, computed with constant shift-add, ADDR_W bits.
- States are encoded as IDLE=0, DRAW=1, CLEAR=2, INFER_START=3, INFER_WAIT=4.
- IDLE:
  - clear edge -> CLEAR. This takes priority over a simultaneous start edge.
  - Otherwise, start edge -> INFER_START.
  - Otherwise, draw_en=1 -> DRAW.
  - Keys are ignored.
- DRAW:
  - Entry clears result_valid. If pen_on=1, entry also writes 1 at the current cursor the next cycle.
  - An accepted move updates the cursor on cycle N. If pen_on=1, img_we=1 with wdata=1 at the new address on cycle N+1.
  - draw_en=0 -> IDLE. Any pending write still issues.
  - start and clear are ignored while in DRAW.
- CLEAR:
  - Clears result_valid.
  - Writes 0 to addresses 0..GRID_W*GRID_H-1, one per cycle: 784 consecutive img_we cycles.
  - After the last write -> IDLE. Keys and edges are ignored during the sweep.
- INFER_START: clears result_valid, asserts nn_start for exactly 1 cycle, then -> INFER_WAIT.
- INFER_WAIT:
  - img_addr = nn_rd_addr; nn_rd_gnt = nn_rd_req (combinational); img_we=0.
  - nn_done=1 -> digit<=nn_result, result_valid<=1, -> IDLE.
- Outside INFER_WAIT: nn_rd_gnt=0 and nn_done is ignored. img_we is never asserted in INFER_START or INFER_WAIT.
- The cursor holds its value across CLEAR and inference.

Decomposition:
- Shared package holds: state encoding; key index constants KEY_DOWN=0, KEY_UP=1, KEY_LEFT=2, KEY_RIGHT=3; GRID_W/GRID_H defaults.
- One natural sub-module: key_debouncer. It takes the synchronized 4-bit key vector and produces a one-cycle move pulse plus a 2-bit direction. It is parameterized by DEBOUNCE_CYCLES.

Test Plan:
1. Assert and release reset -> state=0, cursor=(14,14), img_we=nn_start=nn_rd_gnt=result_valid=0.
2. DEBOUNCE_CYCLES=16, draw_en=pen_on=1, press right x3 then down x3 (each held 40 cycles) -> writes at 406, 407, 408, 409, 437, 465, 493; final cursor=(17,17).
3. Press right held 10 cycles -> no move. Press left and up together -> no move. At x=27, press right -> cursor stays 27, no write.
4. From IDLE, clear edge -> 784 consecutive writes of 0 at addresses 0..783, busy high throughout, then state=0.
5. start edge in IDLE -> one nn_start pulse; nn_rd_gnt tracks nn_rd_req with img_addr=nn_rd_addr; key presses cause no moves; nn_done with nn_result=7 -> digit=7, result_valid=1, state=0.
6. Assert reset during CLEAR at address 300 -> img_we=0 immediately, state=0. After release, start and clear edges arriving on the same cycle -> CLEAR is entered.
